gaussian_conv_stream: RTL and testbench
=======================================

// Module: gaussian_conv_stream
// PURPOSE
//  Downstream consumer of the Gaussian kernel generator. Loads a SIZE x SIZE fixed-point kernel serially in
//  row-major order (row i, then column j). Applies the kernel to a raster pixel stream via line buffers and a
//  sliding window. Emits the blurred valid-region image (no padding) on a valid/ready stream. Feeds the
//  gradient stage.
// PARAMETERS
//  SIZE       5    kernel edge length; odd, >=3
//  IMG_W      64   input image width (pixels)
//  IMG_H      64   input image height (lines)
//  PIX_W      8    pixel width, unsigned
//  COEF_W     17   coefficient width, unsigned Q1.16 (1.0 = 65536)
//  FRAC       16   coefficient fractional bits
// PORTS
//  clk        in   1       clock
//  reset      in   1       asynchronous, active-high
//  coef_start in   1       pulse: abort frame, enter LOAD, clear coef index
//  coef_valid in   1       coefficient strobe (accepted only in LOAD)
//  coef_data  in   COEF_W  coefficient, row-major order
//  kernel_rdy out  1       high in RUN (all SIZE*SIZE coefficients held)
//  in_valid   in   1       pixel valid
//  in_ready   out  1       pixel accepted when in_valid && in_ready
//  in_sof     in   1       marks first pixel of a frame
//  in_pixel   in   PIX_W   input pixel
//  out_valid  out  1       output pixel valid, held until out_ready
//  out_ready  in   1       downstream ready
//  out_sof    out  1       first output pixel of frame
//  out_eof    out  1       last output pixel of frame
//  out_pixel  out  PIX_W   blurred pixel
//  coef_err   out  1       kernel normalisation error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=LOAD, coef idx=0, row=col=0, kernel regs=0; every output 0 (in_ready=0, kernel_rdy=0).
//  FSM LOAD: each coef_valid writes kernel[idx/SIZE][idx%SIZE], idx++.
//    Write of idx=SIZE*SIZE-1 -> RUN next cycle. in_ready=0 throughout.
//  FSM RUN: in_ready = !out_valid || out_ready. coef_valid ignored.
//    coef_start (either state) -> LOAD next cycle; idx=0, row=col=0, out_valid cleared.
//    Line buffers not cleared.
//  Counters: col 0..IMG_W-1, row 0..IMG_H-1, advanced per accepted pixel.
//    Wrap col->0 with row++; after (IMG_H-1, IMG_W-1) both -> 0.
//    in_sof on an accepted pixel forces that pixel to (0,0).
//  Window: SIZE-1 line buffers of IMG_W x PIX_W plus a SIZE x SIZE shift window.
//    Window is updated only on accept.
//  Output: computed from the pixel accepted with row>=SIZE-1 && col>=SIZE-1.
//    Result registered; out_valid is asserted the cycle after accept (latency 1).
//    Output image is (IMG_W-SIZE+1) x (IMG_H-SIZE+1).
//    out_sof at (SIZE-1, SIZE-1); out_eof at (IMG_H-1, IMG_W-1).
//  Arithmetic: sum of SIZE*SIZE products (PIX_W+COEF_W bits each), accumulator width
//    PIX_W+COEF_W+clog2(SIZE*SIZE), no overflow.
//    out = (sum + 2^(FRAC-1)) >> FRAC, saturate to 2^PIX_W-1.
//    Kernel index [0][0] multiplies the oldest (top-left) pixel.
//  out_valid && !out_ready: out_* held stable; no pixel accepted.
//  out_ready is irrelevant when out_valid=0.
//  Reset mid-frame: immediate return to reset state; kernel must be reloaded.
// CONFIGURATION
//  GAUSS_CONV_NORM_CHECK_EN defined: LOAD accumulates the coefficient sum.
//    On entering RUN, coef_err=1 if |sum - 2^FRAC| > SIZE*SIZE, else 0.
//    coef_err is cleared by coef_start or reset. Datapath is unaffected.
//  Undefined: no accumulator; coef_err tied 0.
// TESTING
//  1 Delta kernel (centre 65536, others 0), IMG 8x8 ramp p=8r+c
//    -> 16 outputs, out(r,c)=p(r+2,c+2); sof on 1st, eof on 16th.
//  2 Uniform kernel 2621 x25, constant input 200
//    -> every out = round(200*65525/65536) = 200; coef_err=0.
//  3 All coefficients 4096, input 255 -> out saturates 255.
//    With NORM_CHECK_EN: coef_err=1 after the 25th coef.
//  4 Backpressure: out_ready toggles 1010..., in_valid=1
//    -> no pixel lost or duplicated; out_* stable while stalled.
//  5 coef_start mid-frame after 30 pixels -> in_ready=0, out_valid=0 next cycle.
//    Reload, new frame with in_sof -> correct output.
//  6 reset asserted mid-frame -> all outputs 0 asynchronously; kernel_rdy=0 until 25 coefficients reloaded.

Source files
------------

// File: rtl/gaussian_conv_stream.sv
// Streaming SIZE x SIZE convolution: serial kernel load, line-buffered sliding window, valid-region output.
// Optional macro GAUSS_CONV_NORM_CHECK_EN adds a kernel normalisation check driving coef_err.
module gaussian_conv_stream #(
    parameter int unsigned SIZE   = 5,
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned COEF_W = 17,
    parameter int unsigned FRAC   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coef_start,
    input  logic              coef_valid,
    input  logic [COEF_W-1:0] coef_data,
    output logic              kernel_rdy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [PIX_W-1:0]  in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              coef_err
);

    localparam int unsigned KN    = SIZE * SIZE;
    localparam int unsigned IDX_W = $clog2(KN);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned ACC_W = PIX_W + COEF_W + $clog2(KN);
    localparam int unsigned RES_W = ACC_W + 1;

    typedef enum logic {ST_LOAD, ST_RUN} state_e;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q;
    logic [KN-1:0][COEF_W-1:0]      kern_q;
    logic [ROW_W-1:0]               row_q;
    logic [COL_W-1:0]               col_q;
    logic [SIZE-2:0][PIX_W-1:0]     lb_q [IMG_W];
    logic [PIX_W-1:0]               win_q [SIZE][SIZE];
    logic [PIX_W-1:0]               win_d [SIZE][SIZE];
    logic                           out_valid_q, out_sof_q, out_eof_q;
    logic [PIX_W-1:0]               out_pixel_q;

    logic                           coef_wr, last_coef, accept, in_region;
    logic [ROW_W-1:0]               pos_r;
    logic [COL_W-1:0]               pos_c;
    logic [ACC_W-1:0]               acc;
    logic [RES_W-1:0]               rnd, shf;
    logic [PIX_W-1:0]               res;

    assign coef_wr   = (state_q == ST_LOAD) && coef_valid && !coef_start;
    assign last_coef = coef_wr && (idx_q == IDX_W'(KN - 1));
    assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign pos_r     = in_sof ? '0 : row_q;
    assign pos_c     = in_sof ? '0 : col_q;
    assign in_region = (pos_r >= ROW_W'(SIZE - 1)) && (pos_c >= COL_W'(SIZE - 1));

    assign kernel_rdy = (state_q == ST_RUN);
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign out_pixel  = out_pixel_q;

    always_comb begin
        state_d = state_q;
        if (coef_start) begin
            state_d = ST_LOAD;
        end else if (last_coef) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Kernel store, written row-major by the serial load index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            kern_q <= '0;
        end else if (coef_start) begin
            idx_q <= '0;
        end else if (coef_wr) begin
            kern_q[idx_q] <= coef_data;
            idx_q         <= last_coef ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if (coef_start) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (pos_c == COL_W'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (pos_r == ROW_W'(IMG_H - 1)) ? '0 : pos_r + 1'b1;
            end else begin
                col_q <= pos_c + 1'b1;
                row_q <= pos_r;
            end
        end
    end

    // Window after shifting in the incoming column; row 0 is the oldest line
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE - 1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
        end
        for (int i = 0; i < SIZE - 1; i++) begin
            win_d[i][SIZE-1] = lb_q[pos_c][i];
        end
        win_d[SIZE-1][SIZE-1] = in_pixel;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_q        <= win_d;
            lb_q[pos_c]  <= {in_pixel, lb_q[pos_c][SIZE-2:1]};
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                acc = acc + ACC_W'(win_d[i][j]) * ACC_W'(kern_q[i*SIZE+j]);
            end
        end
        rnd = RES_W'(acc) + RES_W'(1 << (FRAC - 1));
        shf = rnd >> FRAC;
        res = (shf > RES_W'((1 << PIX_W) - 1)) ? '1 : shf[PIX_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_pixel_q <= '0;
        end else if (coef_start) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else if (accept && in_region) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= res;
            out_sof_q   <= (pos_r == ROW_W'(SIZE - 1)) && (pos_c == COL_W'(SIZE - 1));
            out_eof_q   <= (pos_r == ROW_W'(IMG_H - 1)) && (pos_c == COL_W'(IMG_W - 1));
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end
    end

`ifdef GAUSS_CONV_NORM_CHECK_EN
    localparam int unsigned SUM_W = COEF_W + $clog2(KN) + 1;

    logic [SUM_W-1:0] csum_q, csum_d;
    logic             err_q;

    assign csum_d   = csum_q + SUM_W'(coef_data);
    assign coef_err = err_q;

    // Error flag resolves on the final coefficient, i.e. as RUN is entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else if (coef_start) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else if (coef_wr) begin
            csum_q <= csum_d;
            if (last_coef) begin
                err_q <= (csum_d > SUM_W'((1 << FRAC) + KN)) || (csum_d < SUM_W'((1 << FRAC) - KN));
            end
        end
    end
`else
    assign coef_err = 1'b0;
`endif

endmodule

// File: tb/tb_gaussian_conv_stream.sv
// Randomized self-checking bench for gaussian_conv_stream (5x5 kernel, 8x8 image) with a scoreboard model.
module tb_gaussian_conv_stream;

    localparam int S = 5;
    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        coef_start, coef_valid;
    logic [16:0] coef_data;
    logic        kernel_rdy;
    logic        in_valid, in_ready, in_sof;
    logic [7:0]  in_pixel;
    logic        out_valid, out_ready, out_sof, out_eof;
    logic [7:0]  out_pixel;
    logic        coef_err;

    gaussian_conv_stream #(.SIZE(S), .IMG_W(W), .IMG_H(H), .PIX_W(8), .COEF_W(17), .FRAC(16)) dut (
        .clk(clk), .reset(reset),
        .coef_start(coef_start), .coef_valid(coef_valid), .coef_data(coef_data),
        .kernel_rdy(kernel_rdy),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
        .out_pixel(out_pixel), .coef_err(coef_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int px;
        bit sof;
        bit eof;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned kern [S*S];
    int unsigned img  [W*H];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          rdy_mode = 0;
    int          out_cnt  = 0;
    bit          stalled  = 1'b0;
    logic [10:0] held;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_px(input int r, input int c);
        longint s = 0;
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++)
                s += longint'(kern[i*S+j]) * longint'(img[(r-S+1+i)*W + (c-S+1+j)]);
        s = (s + 32768) >>> 16;
        if (s > 255) s = 255;
        return int'(s);
    endfunction

    function automatic bit exp_err();
`ifdef GAUSS_CONV_NORM_CHECK_EN
        longint sum = 0;
        for (int k = 0; k < S*S; k++) sum += longint'(kern[k]);
        return (sum > 65536 + S*S) || (sum < 65536 - S*S);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard and stall-stability monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (stalled) check_eq("stall_hold", {out_valid, out_sof, out_eof, out_pixel}, held);
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("out_pixel", out_pixel, mon_e.px);
                    check_eq("out_sof", out_sof, mon_e.sof);
                    check_eq("out_eof", out_eof, mon_e.eof);
                end
            end
            stalled = out_valid && !out_ready && !coef_start;
            held    = {out_valid, out_sof, out_eof, out_pixel};
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic load_kernel(input bit gaps);
        coef_start = 1'b1;
        @(posedge clk); #1;
        coef_start = 1'b0;
        for (int k = 0; k < S*S; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                coef_valid = 1'b0;
                @(posedge clk); #1;
            end
            coef_valid = 1'b1;
            coef_data  = 17'(kern[k]);
            if (k == S*S-1) begin
                @(negedge clk);
                check_eq("rdy_before_last", kernel_rdy, 0);
            end
            @(posedge clk); #1;
        end
        coef_valid = 1'b0;
        @(negedge clk);
        check_eq("kernel_rdy", kernel_rdy, 1);
        check_eq("coef_err", coef_err, exp_err());
        @(posedge clk); #1;
    endtask

    task automatic feed(input int n, input bit gaps);
        int  k = 0;
        int  waitc = 0;
        bit  acc;
        for (int p = 0; p < n; p++) begin
            if (p / W >= S-1 && p % W >= S-1)
                exp_q.push_back('{model_px(p / W, p % W), (p / W == S-1) && (p % W == S-1),
                                  (p / W == H-1) && (p % W == W-1)});
        end
        while (k < n) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                continue;
            end
            in_valid = 1'b1;
            in_pixel = 8'(img[k]);
            in_sof   = (k == 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                waitc = 0;
            end else if (++waitc > 500) begin
                check_eq("feed_timeout", k, n);
                break;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("drain_left", exp_q.size(), 0);
    endtask

    task automatic rand_kernel();
        for (int k = 0; k < S*S; k++) kern[k] = $urandom_range(0, 5000);
    endtask

    task automatic rand_image();
        for (int k = 0; k < W*H; k++) img[k] = $urandom_range(0, 255);
    endtask

    initial begin
        int c0;
        reset = 1'b1; coef_start = 1'b0; coef_valid = 1'b0; coef_data = '0;
        in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_kernel_rdy", kernel_rdy, 0);
        check_eq("rst_out_pixel", out_pixel, 0);
        check_eq("rst_out_flags", {out_sof, out_eof}, 0);
        check_eq("rst_coef_err", coef_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Delta kernel on a ramp: output is the centre pixel
        for (int k = 0; k < S*S; k++) kern[k] = 0;
        kern[12] = 65536;
        for (int k = 0; k < W*H; k++) img[k] = k;
        load_kernel(1'b0);
        c0 = out_cnt;
        feed(W*H, 1'b0);
        wait_drain();
        check_eq("delta_count", out_cnt - c0, (W-S+1) * (H-S+1));

        // Near-unity uniform kernel on flat input
        for (int k = 0; k < S*S; k++) kern[k] = 2621;
        for (int k = 0; k < W*H; k++) img[k] = 200;
        load_kernel(1'b1);
        feed(W*H, 1'b0);
        wait_drain();

        // Over-unity kernel on white input saturates
        for (int k = 0; k < S*S; k++) kern[k] = 4096;
        for (int k = 0; k < W*H; k++) img[k] = 255;
        load_kernel(1'b0);
        feed(W*H, 1'b1);
        wait_drain();

        // Backpressure with random kernels; coefficient strobes in RUN must be ignored
        rand_kernel();
        load_kernel(1'b1);
        for (int k = 0; k < 5; k++) begin
            coef_valid = 1'b1;
            coef_data  = 17'($urandom_range(0, 131071));
            @(posedge clk); #1;
        end
        coef_valid = 1'b0;
        check_eq("rdy_after_ignored_coef", kernel_rdy, 1);
        rdy_mode = 1;
        rand_image();
        feed(W*H, 1'b0);
        wait_drain();
        rdy_mode = 2;
        for (int f = 0; f < 3; f++) begin
            rand_kernel();
            load_kernel(1'b1);
            rand_image();
            c0 = out_cnt;
            feed(W*H, 1'b1);
            wait_drain();
            check_eq("bp_count", out_cnt - c0, (W-S+1) * (H-S+1));
        end

        // Abort mid-frame, reload and run a fresh frame
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        feed(30, 1'b0);
        coef_start = 1'b1;
        @(posedge clk); #1;
        coef_start = 1'b0;
        @(negedge clk);
        check_eq("abort_in_ready", in_ready, 0);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_kernel_rdy", kernel_rdy, 0);
        @(posedge clk); #1;
        rand_kernel();
        load_kernel(1'b0);
        rand_image();
        feed(W*H, 1'b1);
        wait_drain();

        // Asynchronous reset mid-frame
        feed(45, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_pixel", out_pixel, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        check_eq("mid_rst_kernel_rdy", kernel_rdy, 0);
        check_eq("mid_rst_flags", {out_sof, out_eof, coef_err}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_kernel_rdy", kernel_rdy, 0);
        @(posedge clk); #1;
        rand_kernel();
        load_kernel(1'b1);
        rdy_mode = 2;
        rand_image();
        feed(W*H, 1'b1);
        wait_drain();

        // Partial frame then in_sof restarts the raster at (0,0)
        rand_image();
        feed(20, 1'b1);
        rand_image();
        c0 = out_cnt;
        feed(W*H, 1'b1);
        wait_drain();
        check_eq("sof_resync_count", out_cnt - c0, (W-S+1) * (H-S+1));

        rdy_mode = 0;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
